sinegen_ctrl: RTL and testbench
===============================

# sinegen_ctrl

Frequency-sweep sequencer for the sine generator datapath. It drives the generator's `en`, `incr` and `offset` inputs so the output frequency steps from a start value to a stop value, upward or downward. Each step is held for a programmable number of clock cycles. It sits between a host or top-level test harness and `sinegen`, with `dout1`/`dout2` unchanged.

## Interface
- `ADDR_WIDTH`, 8, width of `incr`/`offset`; matches `sinegen` `ADDR_WIDTH`
- `DWELL_WIDTH`, 16, width of dwell counter and `dwell` input

- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  sweep request, sampled in IDLE only
- `abort`  in  1  terminate sweep; highest priority
- `loop`  in  1  continuous-sweep request (see Configuration)
- `f_start`  in  ADDR_WIDTH  first increment value
- `f_stop`  in  ADDR_WIDTH  final increment value
- `f_step`  in  ADDR_WIDTH  step magnitude; 0 treated as 1
- `dwell`  in  DWELL_WIDTH  cycles per step; 0 treated as 1
- `phase_offset`  in  ADDR_WIDTH  offset for second sine channel
- `en`  out  1  to `sinegen.en`
- `incr`  out  ADDR_WIDTH  to `sinegen.incr`
- `offset`  out  ADDR_WIDTH  to `sinegen.offset`
- `busy`  out  1  high in SWEEP
- `done`  out  1  one-cycle pulse at normal sweep completion

## Operation
- States: IDLE, SWEEP, DONE.
- **IDLE**
  - `en`=0, `busy`=0.
  - On `start`=1 with `abort`=0: latch `f_start`, `f_stop`, `f_step`, `dwell`, `phase_offset` into shadow registers.
  - Load `incr`=`f_start`, `offset`=`phase_offset` and clear the dwell counter, then go to SWEEP.
  - Inputs are ignored after latching until the next IDLE.
- **Direction** is fixed at latch time: up if `f_stop` ≥ `f_start`, else down.
- **SWEEP**
  - `en`=1, `busy`=1.
  - The dwell counter increments each cycle. Expiry occurs when count = effective dwell − 1.
  - On expiry, if `incr` = stop, go to DONE.
  - Otherwise, for an up sweep, `incr` = min(`incr`+step, stop). For a down sweep, `incr` = max(`incr`−step, stop).
  - Compute in ADDR_WIDTH+1 bits so there is no wrap-around. The counter then clears.
- **DONE**
  - `en`=0, `busy`=0, `done`=1 for exactly one cycle.
  - Next state is IDLE, or SWEEP when looping.
- **Abort**: `abort`=1 in any state forces IDLE on the next edge.
  - `en`=0, `busy`=0, and `done` is not asserted.
  - `incr`/`offset` hold their last values.
- **Priorities**
  - `abort` beats `start`.
  - `start` during SWEEP or DONE is ignored.
  - `start` held high in IDLE begins a new sweep on the cycle after DONE exits.
- **Every step, including first and last, lasts exactly effective-dwell cycles.**
  - Sweep length is (number of distinct `incr` values) × dwell cycles.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- Reset values: `en`=0, `incr`=0, `offset`=0, `busy`=0, `done`=0, state IDLE, dwell counter 0.
- `start` is sampled at edge N. `en`=1 and `incr`=`f_start` are visible after edge N, so 1-cycle latency.
- `incr` changes only on dwell expiry edges. `offset` changes only at latch.
- `done` rises on the edge after the final step's last dwell cycle and falls one edge later.
- Back-to-back sweeps: the minimum gap is 2 cycles with `en`=0 (DONE and IDLE). With loop, the gap is 1 cycle (DONE only).
- Reset asserted mid-sweep: outputs go immediately (asynchronously) to reset values. Operation resumes only after `rst` deasserts and a new `start` arrives.

## Configuration
- Macro `SINEGEN_CTRL_LOOP_EN`.
- **Defined**
  - In DONE, if `loop`=1, reload `incr` from shadow `f_start`, clear the dwell counter and return to SWEEP.
  - `done` still pulses every pass.
  - The shadow registers are not reloaded from inputs.
  - `abort` is the only exit besides `loop`=0.
- **Undefined**
  - The `loop` port is present but ignored, and DONE always goes to IDLE.
  - No loop logic is synthesised.

## Test plan
- **Up sweep:** `f_start`=4, `f_stop`=10, `f_step`=3, `dwell`=2, pulse `start` → `incr` sequence 4,4,7,7,10,10. `en`/`busy` high for 6 cycles, then `done`=1 for 1 cycle, then IDLE with `incr`=10.
- **Down sweep with clamp:** `f_start`=10, `f_stop`=4, `f_step`=4, `dwell`=1 → `incr` 10,6,4 (6−4 clamps to 4), then `done`. A `phase_offset` of 64 gives `offset`=64 throughout.
- **Degenerate inputs:** `f_step`=0, `dwell`=0, `f_start`=254, `f_stop`=255 → `incr` 254,255, one cycle each, then `done`. Also `f_start`=`f_stop`=255, `f_step`=200 → a single 255 step with no wrap.
- **Abort and start collision:** abort at cycle 3 of the up-sweep case → `en`=0 the next cycle, no `done`, `incr` holds 7. `start`=`abort`=1 together in IDLE → remains IDLE. `start` pulsed during SWEEP → no effect.
- **Async reset mid-sweep:** drop `rst` between edges during SWEEP → `en`, `incr`, `offset`, `busy` go to 0 immediately. After release, no activity until `start`.
- **Loop (macro defined):** `loop`=1 with the up-sweep case → 4,4,7,7,10,10, then DONE with a `done` pulse, then 4 again. Drop `loop` → ends in IDLE after the next `done`. With the macro undefined, the same stimulus stops after the first `done`.

Source files
------------

// File: rtl/sinegen_ctrl.sv
// rtl/sinegen_ctrl.sv - frequency-sweep sequencer driving sinegen en/incr/offset
// Optional continuous sweep is compiled in with `define SINEGEN_CTRL_LOOP_EN.
module sinegen_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_loop,
  input  logic [ADDR_WIDTH-1:0]  i_f_start,
  input  logic [ADDR_WIDTH-1:0]  i_f_stop,
  input  logic [ADDR_WIDTH-1:0]  i_f_step,
  input  logic [DWELL_WIDTH-1:0] i_dwell,
  input  logic [ADDR_WIDTH-1:0]  i_phase_offset,
  output logic                   o_en,
  output logic [ADDR_WIDTH-1:0]  o_incr,
  output logic [ADDR_WIDTH-1:0]  o_offset,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_stop;
  logic [ADDR_WIDTH-1:0]  r_step;
  logic [DWELL_WIDTH-1:0] r_dwell_m1;
  logic [DWELL_WIDTH-1:0] r_cnt;
  logic                   r_up;
`ifdef SINEGEN_CTRL_LOOP_EN
  logic [ADDR_WIDTH-1:0]  r_first;
`else
  logic                   w_unused_loop;
  assign w_unused_loop = i_loop;
`endif

  logic [ADDR_WIDTH:0]    w_sum;
  logic [ADDR_WIDTH:0]    w_diff;
  logic [ADDR_WIDTH:0]    w_stop_x;
  logic [ADDR_WIDTH-1:0]  w_next_incr;
  logic [ADDR_WIDTH-1:0]  w_step_eff;
  logic [DWELL_WIDTH-1:0] w_dwell_m1;
  logic                   w_expire;

  // One extra bit keeps the clamp comparison free of wrap-around at both ends.
  assign w_stop_x = {1'b0, r_stop};
  assign w_sum    = {1'b0, o_incr} + {1'b0, r_step};
  assign w_diff   = {1'b0, o_incr} - {1'b0, r_step};
  assign w_expire = (r_cnt == r_dwell_m1);

  assign w_step_eff = (i_f_step == '0) ? ADDR_WIDTH'(1) : i_f_step;
  assign w_dwell_m1 = (i_dwell == '0) ? '0 : (i_dwell - DWELL_WIDTH'(1));

  always_comb begin
    w_next_incr = r_stop;
    if (r_up) begin
      if (w_sum <= w_stop_x) w_next_incr = w_sum[ADDR_WIDTH-1:0];
    end else begin
      if (!w_diff[ADDR_WIDTH] && (w_diff >= w_stop_x)) w_next_incr = w_diff[ADDR_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_stop     <= '0;
      r_step     <= '0;
      r_dwell_m1 <= '0;
      r_cnt      <= '0;
      r_up       <= 1'b0;
`ifdef SINEGEN_CTRL_LOOP_EN
      r_first    <= '0;
`endif
      o_en       <= 1'b0;
      o_incr     <= '0;
      o_offset   <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else if (i_abort) begin
      r_state <= S_IDLE;
      o_en    <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_en   <= 1'b0;
          o_busy <= 1'b0;
          o_done <= 1'b0;
          if (i_start) begin
            r_stop     <= i_f_stop;
            r_step     <= w_step_eff;
            r_dwell_m1 <= w_dwell_m1;
            r_up       <= (i_f_stop >= i_f_start);
`ifdef SINEGEN_CTRL_LOOP_EN
            r_first    <= i_f_start;
`endif
            r_cnt      <= '0;
            o_incr     <= i_f_start;
            o_offset   <= i_phase_offset;
            o_en       <= 1'b1;
            o_busy     <= 1'b1;
            r_state    <= S_SWEEP;
          end
        end
        S_SWEEP: begin
          if (w_expire) begin
            r_cnt <= '0;
            if (o_incr == r_stop) begin
              o_en    <= 1'b0;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              o_incr <= w_next_incr;
            end
          end else begin
            r_cnt <= r_cnt + DWELL_WIDTH'(1);
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          r_state <= S_IDLE;
`ifdef SINEGEN_CTRL_LOOP_EN
          if (i_loop) begin
            o_incr  <= r_first;
            r_cnt   <= '0;
            o_en    <= 1'b1;
            o_busy  <= 1'b1;
            r_state <= S_SWEEP;
          end
`endif
        end
        default: begin
          r_state <= S_IDLE;
          o_en    <= 1'b0;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sinegen_ctrl.sv
// tb/tb_sinegen_ctrl.sv - self-checking bench for sinegen_ctrl
// Expected incr sequences come from a queue model built from the sweep rules.
module tb_sinegen_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, loop = 1'b0;
  logic [7:0] f_start = '0, f_stop = '0, f_step = '0, phase_offset = '0;
  logic [15:0] dwell = '0;
  logic       en, busy, done;
  logic [7:0] incr, offset;

  int n_tests = 0;
  int n_fail  = 0;

  sinegen_ctrl #(.ADDR_WIDTH(8), .DWELL_WIDTH(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_loop(loop),
    .i_f_start(f_start), .i_f_stop(f_stop), .i_f_step(f_step), .i_dwell(dwell),
    .i_phase_offset(phase_offset),
    .o_en(en), .o_incr(incr), .o_offset(offset), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: list of incr values, each repeated for the effective dwell.
  task automatic build_model(input int fs, input int fe, input int st, input int dw,
                             output int q[$]);
    int v, s, d;
    q = {};
    v = fs;
    s = (st == 0) ? 1 : st;
    d = (dw == 0) ? 1 : dw;
    while (1) begin
      repeat (d) q.push_back(v);
      if (v == fe) break;
      if (fe >= fs) v = (v + s > fe) ? fe : v + s;
      else          v = (v - s < fe) ? fe : v - s;
    end
  endtask

  task automatic expect_out(input string name, input logic e_en, input logic e_busy,
                            input logic e_done, input int e_incr, input int e_off);
    n_tests++;
    if (en !== e_en || busy !== e_busy || done !== e_done || incr !== 8'(e_incr) || offset !== 8'(e_off)) begin
      n_fail++;
      $display("FAIL %s: got en=%0b busy=%0b done=%0b incr=%0d offset=%0d, want en=%0b busy=%0b done=%0b incr=%0d offset=%0d",
               name, en, busy, done, incr, offset, e_en, e_busy, e_done, e_incr, e_off);
    end
  endtask

  task automatic run_sweep(input string name, input int fs, input int fe, input int st,
                           input int dw, input int po, input bit rnd);
    int q[$];
    build_model(fs, fe, st, dw, q);
    f_start = 8'(fs); f_stop = 8'(fe); f_step = 8'(st); dwell = 16'(dw);
    phase_offset = 8'(po); start = 1'b1;
    tick();
    start = 1'b0;
    foreach (q[i]) begin
      expect_out($sformatf("%s step %0d", name, i), 1'b1, 1'b1, 1'b0, q[i], po);
      if (rnd) begin
        f_start = 8'($urandom); f_stop = 8'($urandom); f_step = 8'($urandom);
        dwell = 16'($urandom); phase_offset = 8'($urandom); start = 1'($urandom);
      end
      tick();
    end
    start = 1'b0;
    expect_out({name, " done"}, 1'b0, 1'b0, 1'b1, fe, po);
    tick();
    expect_out({name, " idle"}, 1'b0, 1'b0, 1'b0, fe, po);
    tick();
    expect_out({name, " idle2"}, 1'b0, 1'b0, 1'b0, fe, po);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    expect_out("reset", 1'b0, 1'b0, 1'b0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    expect_out("post reset idle", 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_directed();
    run_sweep("up", 4, 10, 3, 2, 0, 1'b0);
    run_sweep("down clamp", 10, 4, 4, 1, 64, 1'b0);
    run_sweep("degenerate", 254, 255, 0, 0, 5, 1'b0);
    run_sweep("single 255", 255, 255, 200, 1, 9, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 15; k++) begin
      int fs, fe, st;
      fs = $urandom_range(0, 255);
      fe = $urandom_range(0, 255);
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      run_sweep($sformatf("rand%0d", k), fs, fe, st, $urandom_range(0, 3),
                $urandom_range(0, 255), 1'b1);
    end
  endtask

  task automatic test_abort();
    f_start = 8'd4; f_stop = 8'd10; f_step = 8'd3; dwell = 16'd2; phase_offset = 8'd33;
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_out("abort c1", 1'b1, 1'b1, 1'b0, 4, 33);
    tick();
    expect_out("abort c2", 1'b1, 1'b1, 1'b0, 4, 33);
    tick();
    expect_out("abort c3", 1'b1, 1'b1, 1'b0, 7, 33);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_out("abort stop", 1'b0, 1'b0, 1'b0, 7, 33);
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out("abort no done", 1'b0, 1'b0, 1'b0, 7, 33);
    end
    start = 1'b1; abort = 1'b1;
    tick();
    expect_out("start+abort", 1'b0, 1'b0, 1'b0, 7, 33);
    start = 1'b0; abort = 1'b0;
    tick();
    expect_out("start+abort idle", 1'b0, 1'b0, 1'b0, 7, 33);
  endtask

  task automatic test_back_to_back();
    f_start = 8'd1; f_stop = 8'd2; f_step = 8'd1; dwell = 16'd1; phase_offset = 8'd7;
    start = 1'b1;
    tick();
    expect_out("b2b s1", 1'b1, 1'b1, 1'b0, 1, 7);
    tick();
    expect_out("b2b s2", 1'b1, 1'b1, 1'b0, 2, 7);
    tick();
    expect_out("b2b done", 1'b0, 1'b0, 1'b1, 2, 7);
    tick();
    expect_out("b2b gap", 1'b0, 1'b0, 1'b0, 2, 7);
    tick();
    expect_out("b2b restart", 1'b1, 1'b1, 1'b0, 1, 7);
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_out("b2b abort", 1'b0, 1'b0, 1'b0, 1, 7);
  endtask

  task automatic test_async_reset();
    f_start = 8'd20; f_stop = 8'd200; f_step = 8'd10; dwell = 16'd3; phase_offset = 8'd99;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    expect_out("pre reset", 1'b1, 1'b1, 1'b0, 20, 99);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async reset", 1'b0, 1'b0, 1'b0, 0, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("after reset idle", 1'b0, 1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic test_loop();
    int seq[6] = '{4, 4, 7, 7, 10, 10};
    f_start = 8'd4; f_stop = 8'd10; f_step = 8'd3; dwell = 16'd2; phase_offset = 8'd1;
    loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    foreach (seq[i]) begin
      expect_out($sformatf("loop p1 %0d", i), 1'b1, 1'b1, 1'b0, seq[i], 1);
      tick();
    end
    expect_out("loop done1", 1'b0, 1'b0, 1'b1, 10, 1);
    tick();
`ifdef SINEGEN_CTRL_LOOP_EN
    loop = 1'b0;
    foreach (seq[i]) begin
      expect_out($sformatf("loop p2 %0d", i), 1'b1, 1'b1, 1'b0, seq[i], 1);
      tick();
    end
    expect_out("loop done2", 1'b0, 1'b0, 1'b1, 10, 1);
    tick();
`endif
    loop = 1'b0;
    expect_out("loop end idle", 1'b0, 1'b0, 1'b0, 10, 1);
    tick();
    expect_out("loop end idle2", 1'b0, 1'b0, 1'b0, 10, 1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_loop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
